// File: rtl/icache_dataram_arb.sv
// Data-array scheduler for the two-bank icache: hit reads share the single-port
// array with linefill writes, which wait in a small FIFO with RAW hazard and anti-starvation control.
module icache_dataram_arb #(
  parameter int INDEX_WIDTH     = 8,
  parameter int TXNID_WIDTH     = 8,
  parameter int ENTRY_IDX_WIDTH = 4,
  parameter int LF_DEPTH        = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rd_vld,
  output logic                       rd_rdy,
  input  logic [INDEX_WIDTH-1:0]     rd_index,
  input  logic                       rd_way,
  input  logic [TXNID_WIDTH-1:0]     rd_txnid,
  input  logic                       lf_vld,
  output logic                       lf_rdy,
  input  logic [INDEX_WIDTH-1:0]     lf_index,
  input  logic                       lf_way,
  input  logic [ENTRY_IDX_WIDTH-1:0] lf_entry_idx,
  input  logic [511:0]               lf_data,
  output logic                       mem_en,
  output logic                       mem_wr_en,
  output logic [INDEX_WIDTH:0]       mem_addr,
  output logic [511:0]               mem_wdata,
  input  logic [511:0]               mem_rdata,
  output logic                       lf_done,
  output logic [ENTRY_IDX_WIDTH:0]   lf_done_entry_idx,
  output logic                       up_vld,
  output logic [511:0]               up_data,
  output logic [TXNID_WIDTH-1:0]     up_txnid
);

  localparam int ADDR_W = INDEX_WIDTH + 1;
  localparam int PTR_W  = (LF_DEPTH > 1) ? $clog2(LF_DEPTH) : 1;
  localparam int CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_W'(STARVE_LIMIT)) return v;
    return v + CNT_W'(1);
  endfunction

  logic [ADDR_W-1:0]          lf_addr_q [LF_DEPTH];
  logic [ENTRY_IDX_WIDTH-1:0] lf_ent_q  [LF_DEPTH];
  logic [511:0]               lf_data_q [LF_DEPTH];
  logic [LF_DEPTH-1:0]        lf_vld_q, lf_vld_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           starve_q, starve_d;
  logic                       vld_p1_q;
  logic [TXNID_WIDTH-1:0]     txnid_p1_q;

  logic [ADDR_W-1:0] rd_addr, lf_addr;
  logic              empty, full, push, pop, hz, force_wr, rd_gnt, wr_gnt;

  assign rd_addr = {rd_index, rd_way};
  assign lf_addr = {lf_index, lf_way};

  // Ring occupancy: a slot is live from push until pop, so head/tail flags give empty/full.
  assign empty  = !lf_vld_q[rd_ptr_q];
  assign full   = lf_vld_q[wr_ptr_q];
  assign lf_rdy = !full;
  assign push   = lf_vld && !full;

  always_comb begin
    hz = push && (lf_addr == rd_addr);
    for (int i = 0; i < LF_DEPTH; i++) begin
      if (lf_vld_q[i] && (lf_addr_q[i] == rd_addr)) hz = 1'b1;
    end
  end

  assign force_wr = (starve_q == CNT_W'(STARVE_LIMIT)) && !empty;
  assign rd_rdy   = !hz && !force_wr;
  assign rd_gnt   = rd_vld && rd_rdy;
  assign wr_gnt   = !empty && !rd_gnt;
  assign pop      = wr_gnt;

  always_comb begin
    lf_vld_d = lf_vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      lf_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d           = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      lf_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
  end

  // Counter tracks consecutive cycles a queued write lost to a read.
  always_comb begin
    starve_d = starve_q;
    if (empty || wr_gnt) starve_d = '0;
    else                 starve_d = sat_inc(starve_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lf_vld_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
    end else begin
      lf_vld_q <= lf_vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      lf_addr_q[wr_ptr_q] <= lf_addr;
      lf_ent_q[wr_ptr_q]  <= lf_entry_idx;
      lf_data_q[wr_ptr_q] <= lf_data;
    end
  end

  // Array access stage p0: one grant per cycle drives the single port.
  always_comb begin
    mem_en            = 1'b0;
    mem_wr_en         = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    lf_done           = 1'b0;
    lf_done_entry_idx = '1;
    if (rd_gnt) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end else if (wr_gnt) begin
      mem_en            = 1'b1;
      mem_wr_en         = 1'b1;
      mem_addr          = lf_addr_q[rd_ptr_q];
      mem_wdata         = lf_data_q[rd_ptr_q];
      lf_done           = 1'b1;
      lf_done_entry_idx = {1'b0, lf_ent_q[rd_ptr_q]};
    end
  end

  // Return stage p1: array data arrives one cycle after the read enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      txnid_p1_q <= '0;
    end else begin
      vld_p1_q <= rd_gnt;
      if (rd_gnt) txnid_p1_q <= rd_txnid;
    end
  end

  assign up_vld   = vld_p1_q;
  assign up_txnid = txnid_p1_q;
  assign up_data  = vld_p1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_icache_dataram_arb.sv
// Bench for icache_dataram_arb: queue-based reference model checked every cycle,
// an SRAM stand-in for the data array, and directed scenarios with literal expectations.
module tb_icache_dataram_arb;

  localparam int IW = 4;
  localparam int TW = 4;
  localparam int EW = 3;
  localparam int D  = 2;
  localparam int SL = 4;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          way;
    logic [EW-1:0] ent;
    logic [511:0]  data;
  } lf_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic chk_en = 1'b0;

  logic          rd_vld = 1'b0, rd_way = 1'b0, lf_vld = 1'b0, lf_way = 1'b0;
  logic [IW-1:0] rd_index = '0, lf_index = '0;
  logic [TW-1:0] rd_txnid = '0;
  logic [EW-1:0] lf_entry_idx = '0;
  logic [511:0]  lf_data = '0;
  logic [511:0]  mem_rdata = '0;

  logic          rd_rdy, lf_rdy, mem_en, mem_wr_en, lf_done, up_vld;
  logic [IW:0]   mem_addr;
  logic [511:0]  mem_wdata, up_data;
  logic [EW:0]   lf_done_entry_idx;
  logic [TW-1:0] up_txnid;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  icache_dataram_arb #(
    .INDEX_WIDTH(IW), .TXNID_WIDTH(TW), .ENTRY_IDX_WIDTH(EW),
    .LF_DEPTH(D), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_index(rd_index), .rd_way(rd_way), .rd_txnid(rd_txnid),
    .lf_vld(lf_vld), .lf_rdy(lf_rdy), .lf_index(lf_index), .lf_way(lf_way),
    .lf_entry_idx(lf_entry_idx), .lf_data(lf_data),
    .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .lf_done(lf_done), .lf_done_entry_idx(lf_done_entry_idx),
    .up_vld(up_vld), .up_data(up_data), .up_txnid(up_txnid)
  );

  function automatic logic [511:0] pat(input int a);
    if (a == 11) return {64{8'hA5}};
    return {16{32'hC0DE0000 | 32'(a)}};
  endfunction

  function automatic logic [511:0] lfd(input int k);
    return {16{32'h1F000000 + 32'(k)}};
  endfunction

  // Single-port array stand-in: registered read data, write-through storage.
  logic [511:0] sram [0:31];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) sram[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_wr_en) sram[mem_addr] <= mem_wdata;
      else           mem_rdata <= sram[mem_addr];
    end
  end

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference model: queue of pending lines, expected array contents, loss counter.
  lf_t          q[$];
  lf_t          h;
  logic [511:0] exp_mem [0:31];
  int           m_cnt;
  logic         m_empty, m_full, m_push, m_hz, m_force, m_rg, m_wg;
  logic         eup_vld;
  logic [TW-1:0] eup_txnid;
  logic [511:0] eup_data;
  logic [IW:0]  raddr, e_addr;

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = pat(i);
    m_cnt = 0; eup_vld = 1'b0; eup_txnid = '0; eup_data = '0;
    forever begin
      @(negedge clk);
      raddr   = {rd_index, rd_way};
      m_empty = (q.size() == 0);
      m_full  = (q.size() == D);
      m_push  = lf_vld && !m_full;
      m_hz    = m_push && ({lf_index, lf_way} == raddr);
      foreach (q[i]) if ({q[i].idx, q[i].way} == raddr) m_hz = 1'b1;
      m_force = (m_cnt == SL) && !m_empty;
      m_rg    = rd_vld && !m_hz && !m_force;
      m_wg    = !m_empty && !m_rg;
      if (!m_empty) h = q[0];
      e_addr  = m_rg ? raddr : (m_wg ? {h.idx, h.way} : '0);
      if (chk_en) begin
        check("rd_rdy", rd_rdy, !m_hz && !m_force);
        check("lf_rdy", lf_rdy, !m_full);
        check("mem_en", mem_en, m_rg || m_wg);
        check("mem_wr_en", mem_wr_en, m_wg);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, m_wg ? h.data : '0);
        check("lf_done", lf_done, m_wg);
        check("lf_done_entry_idx", lf_done_entry_idx, m_wg ? {1'b0, h.ent} : {(EW+1){1'b1}});
        check("up_vld", up_vld, eup_vld);
        check("up_txnid", up_txnid, eup_txnid);
        check("up_data", up_data, eup_data);
      end
      @(posedge clk);
      if (m_wg) exp_mem[{h.idx, h.way}] = h.data;
      if (rst) begin
        q.delete();
        m_cnt = 0; eup_vld = 1'b0; eup_txnid = '0; eup_data = '0;
      end else begin
        if (m_wg) h = q.pop_front();
        if (m_push) begin
          h.idx = lf_index; h.way = lf_way; h.ent = lf_entry_idx; h.data = lf_data;
          q.push_back(h);
        end
        if (m_empty || m_wg) m_cnt = 0;
        else if (m_cnt < SL) m_cnt++;
        eup_vld = m_rg;
        if (m_rg) begin
          eup_txnid = rd_txnid;
          eup_data  = exp_mem[raddr];
        end else begin
          eup_data = '0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic set_rd(input logic v, input int idx, input logic w, input int t);
    rd_vld = v; rd_index = IW'(idx); rd_way = w; rd_txnid = TW'(t);
  endtask

  task automatic set_lf(input logic v, input int idx, input logic w, input int e, input logic [511:0] d);
    lf_vld = v; lf_index = IW'(idx); lf_way = w; lf_entry_idx = EW'(e); lf_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int li;
    logic acc;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0; chk_en = 1'b1;

    // Reset state
    at_neg;
    check("rst_up_vld", up_vld, 1'b0);
    check("rst_up_data", up_data, '0);
    check("rst_up_txnid", up_txnid, '0);
    check("rst_lf_done", lf_done, 1'b0);
    check("rst_lf_done_idx", lf_done_entry_idx, 4'hF);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_lf_rdy", lf_rdy, 1'b1);
    cyc;

    // Read only
    set_rd(1, 5, 1, 3);
    at_neg;
    check("t1_rd_rdy", rd_rdy, 1'b1);
    check("t1_mem_en", mem_en, 1'b1);
    check("t1_mem_wr_en", mem_wr_en, 1'b0);
    check("t1_mem_addr", mem_addr, 5'd11);
    cyc;
    set_rd(0, 0, 0, 0);
    at_neg;
    check("t1_up_vld", up_vld, 1'b1);
    check("t1_up_txnid", up_txnid, 4'd3);
    check("t1_up_data", up_data, {64{8'hA5}});
    cyc;

    // Write only, then read the line back
    set_lf(1, 2, 0, 1, lfd(2));
    at_neg;
    check("t2_lf_rdy", lf_rdy, 1'b1);
    check("t2_mem_en_idle", mem_en, 1'b0);
    cyc;
    set_lf(0, 0, 0, 0, '0);
    at_neg;
    check("t2_mem_wr_en", mem_wr_en, 1'b1);
    check("t2_mem_addr", mem_addr, 5'd4);
    check("t2_lf_done", lf_done, 1'b1);
    check("t2_lf_done_idx", lf_done_entry_idx, 4'd1);
    check("t2_mem_wdata", mem_wdata, lfd(2));
    cyc;
    set_rd(1, 2, 0, 5);
    at_neg; cyc;
    set_rd(0, 0, 0, 0);
    at_neg;
    check("t2_up_vld", up_vld, 1'b1);
    check("t2_up_txnid", up_txnid, 4'd5);
    check("t2_up_data", up_data, lfd(2));
    cyc;

    // Starvation: four reads win, then the queued write is forced
    set_lf(1, 9, 0, 4, lfd(9));
    set_rd(1, 1, 0, 0);
    at_neg;
    check("t3_rd_rdy_push", rd_rdy, 1'b1);
    cyc;
    set_lf(0, 0, 0, 0, '0);
    for (int i = 1; i <= 4; i++) begin
      set_rd(1, i + 1, 0, i);
      at_neg;
      check("t3_rd_rdy_win", rd_rdy, 1'b1);
      check("t3_no_write", mem_wr_en, 1'b0);
      cyc;
    end
    set_rd(1, 6, 0, 6);
    at_neg;
    check("t3_forced_rd_rdy", rd_rdy, 1'b0);
    check("t3_forced_wr", mem_wr_en, 1'b1);
    check("t3_forced_addr", mem_addr, 5'd18);
    cyc;
    at_neg;
    check("t3_resume_rd_rdy", rd_rdy, 1'b1);
    check("t3_resume_wr", mem_wr_en, 1'b0);
    cyc;
    set_rd(0, 0, 0, 0);

    // Hazard: read of a line still queued waits for its write
    set_lf(1, 7, 1, 5, lfd(7));
    set_rd(1, 7, 1, 9);
    at_neg;
    check("t4_push_hz", rd_rdy, 1'b0);
    check("t4_push_idle", mem_en, 1'b0);
    cyc;
    set_lf(0, 0, 0, 0, '0);
    at_neg;
    check("t4_hz_rd_rdy", rd_rdy, 1'b0);
    check("t4_hz_wr", mem_wr_en, 1'b1);
    check("t4_hz_addr", mem_addr, 5'd15);
    check("t4_hz_done_idx", lf_done_entry_idx, 4'd5);
    cyc;
    at_neg;
    check("t4_retry_rd_rdy", rd_rdy, 1'b1);
    check("t4_retry_addr", mem_addr, 5'd15);
    cyc;
    set_rd(0, 0, 0, 0);
    at_neg;
    check("t4_up_vld", up_vld, 1'b1);
    check("t4_up_txnid", up_txnid, 4'd9);
    check("t4_up_data", up_data, lfd(7));
    cyc;

    // Full FIFO under continuous reads, five linefills to wrap the pointers
    li = 0;
    for (int c = 0; c < 60 && li < 5; c++) begin
      set_rd(1, c % 4, 0, c);
      set_lf(1, 10 + li, li[0], li, lfd(10 + li));
      at_neg;
      if (c == 2) check("t5_full_lf_rdy", lf_rdy, 1'b0);
      if (c == 5) check("t5_forced_pop", mem_wr_en, 1'b1);
      if (c == 6) check("t5_reopen_lf_rdy", lf_rdy, 1'b1);
      acc = lf_rdy;
      cyc;
      if (acc) li++;
    end
    check("t5_all_pushed", li, 5);
    set_rd(0, 0, 0, 0);
    set_lf(0, 0, 0, 0, '0);
    for (int i = 0; i < 6; i++) begin at_neg; cyc; end
    for (int j = 0; j < 5; j++) begin
      set_rd(1, 10 + j, j[0], j);
      at_neg; cyc;
    end
    set_rd(0, 0, 0, 0);
    at_neg;
    check("t5_last_up_vld", up_vld, 1'b1);
    check("t5_last_up_data", up_data, lfd(14));
    cyc;

    // Reset one cycle after a read grant, with two lines queued
    set_rd(1, 1, 1, 7);
    set_lf(1, 3, 0, 2, lfd(30));
    at_neg; cyc;
    set_rd(1, 2, 1, 8);
    set_lf(1, 4, 1, 3, lfd(31));
    at_neg; cyc;
    set_lf(0, 0, 0, 0, '0);
    set_rd(1, 0, 1, 10);
    at_neg;
    check("t6_rd_grant", rd_rdy, 1'b1);
    check("t6_fifo_full", lf_rdy, 1'b0);
    cyc;
    rst = 1'b1;
    set_rd(0, 0, 0, 0);
    at_neg; cyc;
    rst = 1'b0;
    at_neg;
    check("t6_up_vld", up_vld, 1'b0);
    check("t6_up_data", up_data, '0);
    check("t6_up_txnid", up_txnid, '0);
    check("t6_lf_rdy", lf_rdy, 1'b1);
    check("t6_lf_done", lf_done, 1'b0);
    check("t6_lf_done_idx", lf_done_entry_idx, 4'hF);
    check("t6_mem_en", mem_en, 1'b0);
    cyc;
    at_neg; cyc;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/icache_dataram_arb.md
Name: icache_dataram_arb

Overview:
- Scheduler for the two-bank icache data array (2x256b, address {index,way}).
- Shares the single-port array between hit reads from the tag pipeline and linefill writes from downstream rxdat.
- Linefill writes queue in a small FIFO, so reads no longer stall for the whole linefill beat.
- Includes a read-after-write hazard block against queued lines and an anti-starvation counter for writes.

Parameters:
INDEX_WIDTH, ICACHE_INDEX_WIDTH, set index width
TXNID_WIDTH, ICACHE_REQ_TXNID_WIDTH, upstream txnid width
ENTRY_IDX_WIDTH, MSHR_ENTRY_INDEX_WIDTH, MSHR entry index width
LF_DEPTH, 2, linefill FIFO depth (power of 2, >=2)
STARVE_LIMIT, 4, consecutive lost cycles before a write is forced

Ports:
clk  in  1  clock
rst  in  1  reset
rd_vld  in  1  hit read request
rd_rdy  out  1  read accepted
rd_index  in  INDEX_WIDTH  read set index
rd_way  in  1  read way
rd_txnid  in  TXNID_WIDTH  read txnid
lf_vld  in  1  linefill write request
lf_rdy  out  1  linefill accepted into FIFO
lf_index  in  INDEX_WIDTH  linefill set index
lf_way  in  1  linefill dest way
lf_entry_idx  in  ENTRY_IDX_WIDTH  owning MSHR entry
lf_data  in  512  cacheline
mem_en  out  1  array enable
mem_wr_en  out  1  1 = write, 0 = read
mem_addr  out  INDEX_WIDTH+1  {index,way}
mem_wdata  out  512  {bank1,bank0}
mem_rdata  in  512  array read data, valid 1 cycle after read enable
lf_done  out  1  pulse: line written to array
lf_done_entry_idx  out  ENTRY_IDX_WIDTH+1  entry of written line; all-ones when idle
up_vld  out  1  read data valid
up_data  out  512  read data
up_txnid  out  TXNID_WIDTH  read txnid

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates occur on posedge clk; rst is sampled only at posedge clk.
- Reset values:
  - FIFO empty.
  - Starvation counter 0.
  - up_vld 0, up_txnid 0, up_data 0.
  - lf_done 0, lf_done_entry_idx all-ones.
  - mem_en 0.
- A read in flight when rst is sampled is dropped: up_vld is 0 in the following cycle.
- FIFO:
  - lf_rdy = !full. lf_rdy does not depend on lf_vld.
  - Push on lf_vld && lf_rdy.
  - Registered storage with no bypass: a pushed entry is eligible for arbitration the next cycle.
  - Push and pop in the same cycle are legal when the FIFO is not full. Count is unchanged and pointers wrap mod LF_DEPTH.
- Hazard: hz = 1 if {rd_index,rd_way} equals the {index,way} of any valid FIFO entry, or of the entry being pushed this cycle.
- Force: force_wr = (starve_cnt == STARVE_LIMIT) && !empty.
- Arbitration, per cycle:
  - rd_rdy = !hz && !force_wr.
  - Read grant = rd_vld && rd_rdy.
  - Write grant = !empty && !read grant.
  - Reads win by default; forced or hazard-blocked cycles let the write go.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when !empty and no write is granted.
  - Clears on write grant or when the FIFO is empty.
- Read grant, same cycle:
  - mem_en=1, mem_wr_en=0, mem_addr={rd_index,rd_way}, mem_wdata=0.
- Read grant, next cycle:
  - up_vld=1, up_txnid=registered rd_txnid, up_data=mem_rdata.
  - Read latency is 1 cycle. up_data is 0 when up_vld=0.
- Write grant, same cycle:
  - mem_en=1, mem_wr_en=1, mem_addr={head.index,head.way}, mem_wdata=head.data.
  - FIFO pops.
  - lf_done=1 and lf_done_entry_idx={1'b0,head.entry_idx}; both are combinational.
- No grant: mem_en=0, mem_wr_en=0, mem_addr=0.
- Upstream has no backpressure: up_vld is a one-cycle pulse per accepted read.
- Order: writes retire in FIFO order. A read blocked by a hazard is accepted only after the matching entry has been written.

Test Plan:
- Read only: rd_vld=1, rd_index=5, rd_way=1, rd_txnid=3 in cycle N, array preloaded with 0xA5.. at address 11 -> rd_rdy=1 in N; mem_en=1, mem_wr_en=0, mem_addr=11 in N; in N+1 up_vld=1, up_txnid=3, up_data=0xA5...
- Write only: lf_vld pulse with index=2, way=0, entry=1 into an empty FIFO -> lf_rdy=1; in the next cycle mem_wr_en=1, mem_addr=4, lf_done=1, lf_done_entry_idx=1; a subsequent read of address 4 returns lf_data.
- Starvation: FIFO holds 1 entry while rd_vld=1 continuously on non-hazard addresses -> 4 read grants, then rd_rdy=0 for one cycle while the write is granted, then reads resume; the counter restarts from 0.
- Hazard: FIFO holds index=7, way=1; read of the same address -> rd_rdy=0 until the write cycle, and up_data after the retry equals the new line.
- Full FIFO: push 2 entries while reads are held at continuous rd_vld=1 -> lf_rdy=0 after the second push, then returns to 1 on the first forced pop; pointer wrap is verified over 5 linefills.
- Reset mid-operation: assert rst one cycle after a read grant with the FIFO holding 2 entries -> the next cycle shows up_vld=0, lf_rdy=1, no lf_done, and all outputs at their reset values.
